ifetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the 5-stage MIPS pipeline. Owns the PC and drives the

---
 rtl/cpu_defs_pkg.sv | 21 ++
 rtl/pc_next_sel.sv | 49 ++++
 rtl/ifetch_ctrl.sv | 103 ++++++++++
 tb/tb_ifetch_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package cpu_defs_pkg;

  // Fetch sequencer state: idle after reset, running, or halted until reset.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0080;
  localparam logic [31:0] NOP_INST_DEF   = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES     = 32'd4;

  // Force a redirect address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Priority selector for the next PC and the output-register actions.
// Priority while running: exception > branch > halt > load/stall.
import cpu_defs_pkg::*;

module pc_next_sel #(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        run,
  input  logic [31:0] pc,
  input  logic        exc_req,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        halt_req,
  input  logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_next,
  output logic        load,
  output logic        squash,
  output logic        halt_go
);

  // Low two target bits are deliberately discarded; this keeps them visibly consumed.
  logic unused_br_bits;
  assign unused_br_bits = ^br_target[1:0];

  // Select next pc and the action on the output registers.
  always_comb begin
    pc_next = pc;
    load    = 1'b0;
    squash  = 1'b0;
    halt_go = 1'b0;
    if (run) begin
      if (exc_req) begin
        pc_next = EXC_VECTOR;
        squash  = 1'b1;
      end else if (br_taken) begin
        pc_next = word_align(br_target);
        squash  = 1'b1;
      end else if (halt_req) begin
        halt_go = 1'b1;
        squash  = 1'b1;
      end else if (!out_valid || out_ready) begin
        pc_next = pc + INST_BYTES;
        load    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory
// address combinationally and registers each returned word into IF/ID.
//
// Handshake: out_valid/out_pc/out_inst/out_pc4 are registered. A word is
// transferred to ID on a rising edge where out_valid && out_ready. While
// out_valid && !out_ready the word and the PC are held unchanged; only a
// redirect, halt or reset may discard a held word. A new word is loaded
// whenever the output register is empty or being consumed.
import cpu_defs_pkg::*;

module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         halt_req,
  input  logic         exc_req,
  input  logic         br_taken,
  input  logic [31:0]  br_target,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_inst,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [31:0]  out_pc,
  output logic [31:0]  out_inst,
  output logic [31:0]  out_pc4,
  output logic         busy,
  output logic [31:0]  fetch_cnt,
  output fetch_state_t dbg_state
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic         load, squash, halt_go;

  assign imem_addr = pc;
  assign busy      = (state == RUN);
  assign dbg_state = state;

  pc_next_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_sel (
    .run      (state == RUN),
    .pc       (pc),
    .exc_req  (exc_req),
    .br_taken (br_taken),
    .br_target(br_target),
    .halt_req (halt_req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pc_next  (pc_next),
    .load     (load),
    .squash   (squash),
    .halt_go  (halt_go)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: start only matters in IDLE, HALT is left only by reset.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (halt_go) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // PC register; the selector holds it outside RUN and during stalls.
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  // IF/ID output registers and the issued-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= 32'h0;
      out_inst  <= NOP_INST;
      out_pc4   <= 32'h0;
      fetch_cnt <= 32'h0;
    end else if (squash) begin
      out_valid <= 1'b0;
      out_inst  <= NOP_INST;
    end else if (load) begin
      out_valid <= 1'b1;
      out_pc    <= pc;
      out_inst  <= imem_inst;
      out_pc4   <= pc + INST_BYTES;
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a combinational instruction memory.
import cpu_defs_pkg::*;

module tb_ifetch_ctrl;

  logic         clk = 1'b0;
  logic         rst, start, halt_req, exc_req, br_taken, out_ready;
  logic [31:0]  br_target, imem_addr, imem_inst;
  logic         out_valid, busy;
  logic [31:0]  out_pc, out_inst, out_pc4, fetch_cnt;
  fetch_state_t dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .exc_req(exc_req),
    .br_taken(br_taken), .br_target(br_target), .imem_addr(imem_addr),
    .imem_inst(imem_inst), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_inst(out_inst), .out_pc4(out_pc4), .busy(busy),
    .fetch_cnt(fetch_cnt), .dbg_state(dbg_state)
  );

  // Instruction memory contents: a distinct, non-NOP word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'h2400, a[17:2]};
  endfunction

  always_comb imem_inst = mem_word(imem_addr);

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; halt_req = 0; exc_req = 0; br_taken = 0;
    br_target = 0; out_ready = 0;
    step(); step();
    rst = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
    total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=0", out_inst); end
    total++; if (out_pc4 !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%h exp=0", out_pc4); end
    total++; if (fetch_cnt !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", fetch_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%h exp=0", busy); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    out_ready = 1;
    step();
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL idle_hold got=%0d exp=%0d", dbg_state, IDLE); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%h exp=0", out_valid); end
  endtask

  task automatic test_sequential();
    start = 1;
    step();
    start = 0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL seq_busy got=%h exp=1", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL seq_first_valid got=%h exp=0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d got=%h exp=1", i, out_valid); end
      total++; if (out_pc !== 32'(4*i)) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, out_pc, 32'(4*i)); end
      total++; if (out_inst !== mem_word(32'(4*i))) begin bad++; $display("FAIL seq_inst%0d got=%h exp=%h", i, out_inst, mem_word(32'(4*i))); end
      total++; if (out_pc4 !== 32'(4*i+4)) begin bad++; $display("FAIL seq_pc4%0d got=%h exp=%h", i, out_pc4, 32'(4*i+4)); end
    end
    total++; if (fetch_cnt !== 32'd3) begin bad++; $display("FAIL seq_cnt got=%0d exp=3", fetch_cnt); end
  endtask

  task automatic test_stall();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_pc !== 32'h8) begin bad++; $display("FAIL stall_pc%0d got=%h exp=8", i, out_pc); end
      total++; if (out_inst !== mem_word(32'h8)) begin bad++; $display("FAIL stall_inst%0d got=%h exp=%h", i, out_inst, mem_word(32'h8)); end
      total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL stall_addr%0d got=%h exp=c", i, imem_addr); end
      total++; if (fetch_cnt !== 32'd3) begin bad++; $display("FAIL stall_cnt%0d got=%0d exp=3", i, fetch_cnt); end
    end
    out_ready = 1;
    step();
    total++; if (out_pc !== 32'hC) begin bad++; $display("FAIL release_pc got=%h exp=c", out_pc); end
    total++; if (fetch_cnt !== 32'd4) begin bad++; $display("FAIL release_cnt got=%0d exp=4", fetch_cnt); end
  endtask

  task automatic test_branch();
    br_taken = 1; br_target = 32'h0000_0052;
    step();
    br_taken = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL br_bubble_valid got=%h exp=0", out_valid); end
    total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL br_bubble_inst got=%h exp=0", out_inst); end
    total++; if (imem_addr !== 32'h50) begin bad++; $display("FAIL br_addr got=%h exp=50", imem_addr); end
    total++; if (fetch_cnt !== 32'd4) begin bad++; $display("FAIL br_cnt got=%0d exp=4", fetch_cnt); end
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL br_tgt_valid got=%h exp=1", out_valid); end
    total++; if (out_pc !== 32'h50) begin bad++; $display("FAIL br_tgt_pc got=%h exp=50", out_pc); end
    total++; if (out_inst !== mem_word(32'h50)) begin bad++; $display("FAIL br_tgt_inst got=%h exp=%h", out_inst, mem_word(32'h50)); end
  endtask

  task automatic test_exc_over_branch();
    exc_req = 1; br_taken = 1; br_target = 32'h0000_0300;
    step();
    exc_req = 0; br_taken = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL exc_bubble got=%h exp=0", out_valid); end
    total++; if (imem_addr !== 32'h80) begin bad++; $display("FAIL exc_addr got=%h exp=80", imem_addr); end
    step();
    total++; if (out_pc !== 32'h80) begin bad++; $display("FAIL exc_pc got=%h exp=80", out_pc); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL exc_valid got=%h exp=1", out_valid); end
    total++; if (fetch_cnt !== 32'd6) begin bad++; $display("FAIL exc_cnt got=%0d exp=6", fetch_cnt); end
  endtask

  task automatic test_halt();
    halt_req = 1;
    step();
    halt_req = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL halt_valid got=%h exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL halt_busy got=%h exp=0", busy); end
    total++; if (imem_addr !== 32'h84) begin bad++; $display("FAIL halt_addr got=%h exp=84", imem_addr); end
    start = 1;
    step(); step();
    start = 0;
    total++; if (dbg_state !== HALT) begin bad++; $display("FAIL halt_start_ignored got=%0d exp=%0d", dbg_state, HALT); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL halt_hold_valid got=%h exp=0", out_valid); end
    total++; if (fetch_cnt !== 32'd6) begin bad++; $display("FAIL halt_cnt got=%0d exp=6", fetch_cnt); end
    rst = 1;
    step();
    rst = 0;
    total++; if (fetch_cnt !== 32'd0) begin bad++; $display("FAIL halt_rst_cnt got=%0d exp=0", fetch_cnt); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL halt_rst_state got=%0d exp=%0d", dbg_state, IDLE); end
    start = 1;
    step();
    start = 0;
    step();
    total++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin bad++; $display("FAIL resume_pc got=%h/%h exp=0/1", out_pc, out_valid); end
    total++; if (fetch_cnt !== 32'd1) begin bad++; $display("FAIL resume_cnt got=%0d exp=1", fetch_cnt); end
  endtask

  task automatic test_wrap_and_reset();
    br_taken = 1; br_target = 32'hFFFF_FFFF;
    step();
    br_taken = 0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_align got=%h exp=fffffffc", imem_addr); end
    step();
    total++; if (out_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_outpc got=%h exp=fffffffc", out_pc); end
    total++; if (out_pc4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h exp=0", out_pc4); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
    step();
    total++; if (out_pc !== 32'h0 || out_inst !== mem_word(32'h0)) begin bad++; $display("FAIL wrap_next got=%h/%h exp=0/%h", out_pc, out_inst, mem_word(32'h0)); end
    total++; if (fetch_cnt !== 32'd3) begin bad++; $display("FAIL wrap_cnt got=%0d exp=3", fetch_cnt); end
    out_ready = 0;
    step();
    br_taken = 1; br_target = 32'h0000_0040;
    step();
    br_taken = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_redirect_squash got=%h exp=0", out_valid); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL stall_redirect_addr got=%h exp=40", imem_addr); end
    step();
    total++; if (out_pc !== 32'h40 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_redirect_load got=%h/%h exp=40/1", out_pc, out_valid); end
    step();
    total++; if (out_pc !== 32'h40 || fetch_cnt !== 32'd4) begin bad++; $display("FAIL stall_redirect_hold got=%h/%0d exp=40/4", out_pc, fetch_cnt); end
    rst = 1;
    step();
    rst = 0;
    total++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 || out_pc4 !== 32'h0) begin bad++; $display("FAIL midrst_out got=%h/%h/%h/%h exp=0/0/0/0", out_valid, out_pc, out_inst, out_pc4); end
    total++; if (fetch_cnt !== 32'h0 || busy !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL midrst_state got=%0d/%h/%h exp=0/0/0", fetch_cnt, busy, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_exc_over_branch();
    test_halt();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
